// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage (master) and the instruction memory (slave).
interface if_stage_if #(
  parameter int unsigned PC_W = 32
) ();
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ready;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID instruction register, stall/redirect/memory-wait.
// Optional fetch/bubble performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_WORD = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  if_stage_if.master      imem,
  output logic [31:0]     IR,
  output logic [PC_W-1:0] PC_1,
  output logic            ir_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     bubble_cnt
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StWait} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;

  // PC+1 wraps naturally at the PC_W boundary.
  assign pc_inc         = pc_q + PC_W'(1);
  assign imem.imem_addr = pc_q;

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      IR       <= NOP_WORD;
      PC_1     <= '0;
      ir_valid <= 1'b0;
`ifdef IF_PERF_CNT_EN
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
`endif
    end else begin
      unique case (state_q)
        // First cycle out of reset: no fetch, redirects ignored.
        StBoot: state_q <= StRun;
        StRun, StWait: begin
          if (br_taken) begin
            // Squash the wrong-path fetch even when stalled or memory not ready.
            pc_q     <= br_target;
            IR       <= NOP_WORD;
            ir_valid <= 1'b0;
            state_q  <= StRun;
`ifdef IF_PERF_CNT_EN
            bubble_cnt <= sat_inc(bubble_cnt);
`endif
          end else if (!stall) begin
            if (imem.imem_ready) begin
              IR       <= imem.imem_rdata;
              PC_1     <= pc_inc;
              ir_valid <= 1'b1;
              pc_q     <= pc_inc;
              state_q  <= StRun;
`ifdef IF_PERF_CNT_EN
              fetch_cnt <= sat_inc(fetch_cnt);
`endif
            end else begin
              // Retry the same address next cycle; a bubble goes downstream meanwhile.
              IR       <= NOP_WORD;
              ir_valid <= 1'b0;
              state_q  <= StWait;
`ifdef IF_PERF_CNT_EN
              bubble_cnt <= sat_inc(bubble_cnt);
`endif
            end
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a 32-bit and a 4-bit PC instance run the same stimulus and are
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ready;
  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_stage_if #(.PC_W(32)) bus32 ();
  if_stage_if #(.PC_W(4))  bus4 ();

  assign bus32.imem_ready = ready;
  assign bus32.imem_rdata = mem[bus32.imem_addr[7:0]];
  assign bus4.imem_ready  = ready;
  assign bus4.imem_rdata  = mem[{4'b0, bus4.imem_addr}];

  logic [31:0] ir32, pc1_32, ir4;
  logic [3:0]  pc1_4;
  logic        v32, v4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fc32, bc32, fc4, bc4;
`endif

  if_stage #(.PC_W(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .imem      (bus32),
    .IR        (ir32),
    .PC_1      (pc1_32),
    .ir_valid  (v32)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fc32),
    .bubble_cnt(bc32)
`endif
  );

  if_stage #(.PC_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target[3:0]),
    .imem      (bus4),
    .IR        (ir4),
    .PC_1      (pc1_4),
    .ir_valid  (v4)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt (fc4),
    .bubble_cnt(bc4)
`endif
  );

  // Reference state per instance (0: 32-bit PC, 1: 4-bit PC).
  logic [31:0] m_pc [2];
  logic [31:0] m_ir [2];
  logic [31:0] m_pc1[2];
  logic        m_v  [2];
  logic        m_boot[2];
  logic [31:0] m_fc [2];
  logic [31:0] m_bc [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_step(input int i);
    logic [31:0] mask;
    mask = (i == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
    if (rst) begin
      m_pc[i] = 32'd0; m_ir[i] = 32'd0; m_pc1[i] = 32'd0; m_v[i] = 1'b0;
      m_boot[i] = 1'b1; m_fc[i] = 32'd0; m_bc[i] = 32'd0;
    end else if (m_boot[i]) begin
      m_boot[i] = 1'b0;
    end else if (br_taken) begin
      m_pc[i] = br_target & mask; m_ir[i] = 32'd0; m_v[i] = 1'b0; m_bc[i] = bump(m_bc[i]);
    end else if (!stall) begin
      if (ready) begin
        m_ir[i]  = mem[m_pc[i][7:0]];
        m_pc[i]  = (m_pc[i] + 32'd1) & mask;
        m_pc1[i] = m_pc[i];
        m_v[i]   = 1'b1;
        m_fc[i]  = bump(m_fc[i]);
      end else begin
        m_ir[i] = 32'd0; m_v[i] = 1'b0; m_bc[i] = bump(m_bc[i]);
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare both instances after the edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic rdy);
    rst = r; stall = s; br_taken = b; br_target = t; ready = rdy;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_eq("addr32",  bus32.imem_addr,        m_pc[0]);
    check_eq("ir32",    ir32,                   m_ir[0]);
    check_eq("pc1_32",  pc1_32,                 m_pc1[0]);
    check_eq("valid32", {31'b0, v32},           {31'b0, m_v[0]});
    check_eq("addr4",   {28'b0, bus4.imem_addr}, m_pc[1]);
    check_eq("ir4",     ir4,                    m_ir[1]);
    check_eq("pc1_4",   {28'b0, pc1_4},         m_pc1[1]);
    check_eq("valid4",  {31'b0, v4},            {31'b0, m_v[1]});
`ifdef IF_PERF_CNT_EN
    check_eq("fetch32",  fc32, m_fc[0]);
    check_eq("bubble32", bc32, m_bc[0]);
    check_eq("fetch4",   fc4,  m_fc[1]);
    check_eq("bubble4",  bc4,  m_bc[1]);
`endif
  endtask

  initial begin
    logic [31:0] tgt;
    for (int a = 0; a < 256; a++) mem[a] = $urandom();
    mem[0] = 32'h0410_0000; mem[1] = 32'h0520_8000;
    mem[2] = 32'h4030_0000; mem[3] = 32'h0000_0000;

    // Reset, boot, sequential fetch of mem[0..2].
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("boot_ir", ir32, 32'h0);
    cyc(0, 0, 0, 0, 1);
    check_eq("first_ir", ir32, 32'h0410_0000);
    check_eq("first_pc1", pc1_32, 32'd1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("seq_ir2", ir32, 32'h4030_0000);

    // Stall three cycles holding mem[2], then resume with mem[3].
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 1);
      check_eq("stall_pc1", pc1_32, 32'd3);
      check_eq("stall_addr", bus32.imem_addr, 32'd3);
    end
    cyc(0, 0, 0, 0, 1);
    check_eq("resume_pc1", pc1_32, 32'd4);

    // Redirect to 0x40 while stalled.
    cyc(0, 1, 1, 32'h40, 1);
    check_eq("redir_valid", {31'b0, v32}, 32'd0);
    check_eq("redir_addr", bus32.imem_addr, 32'h40);
    cyc(0, 0, 0, 0, 1);
    check_eq("redir_pc1", pc1_32, 32'h41);

    // Memory wait at PC=5 for two cycles.
    cyc(0, 0, 1, 32'd5, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_eq("wait_addr", bus32.imem_addr, 32'd5);
    cyc(0, 0, 0, 0, 1);
    check_eq("wait_pc1", pc1_32, 32'd6);

    // Wrap: 4-bit PC from 15, 32-bit PC from all-ones.
    cyc(0, 0, 1, 32'hFFFF_FFFF, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("wrap4_pc1", {28'b0, pc1_4}, 32'd0);
    check_eq("wrap4_addr", {28'b0, bus4.imem_addr}, 32'd0);
    check_eq("wrap32_pc1", pc1_32, 32'd0);

    // Reset in the middle of a stall and of a memory wait.
    cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 1, 32'h77, 0);
    cyc(0, 0, 1, 32'h99, 1);
    check_eq("boot_ignores_br", bus32.imem_addr, 32'd0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 255));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
